factorial_seq: RTL and testbench



---
 rtl/factorial_seq.sv | 103 ++++++++++
 tb/tb_factorial_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/factorial_seq.sv
// Sequential n! / n!! engine, one multiply per cycle, valid/ready in and out.
// Ports: clk, rst_n, in_valid/in_ready/in_num/in_mode, out_valid/out_ready/out_fact/out_ovf, busy.
module factorial_seq #(
  parameter int WIDTH   = 32,
  parameter int N_WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_WIDTH-1:0] in_num,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_fact,
  output logic               out_ovf,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam logic [N_WIDTH-1:0] ONE  = N_WIDTH'(1);
  localparam logic [WIDTH-1:0]   SAT  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   W1   = WIDTH'(1);

  state_t               state;
  logic [WIDTH-1:0]     acc;
  logic [N_WIDTH-1:0]   cnt;
  logic [1:0]           step;
  logic                 ovf;

  logic [WIDTH+N_WIDTH-1:0] prod;
  logic [N_WIDTH-1:0]       step_n;
  logic                     ovf_nxt;
  logic                     last;

  assign prod    = {{N_WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, cnt};
  assign ovf_nxt = ovf | (|prod[WIDTH+N_WIDTH-1:WIDTH]);
  assign step_n  = {{(N_WIDTH-2){1'b0}}, step};
  // Compared before decrement, so cnt never wraps.
  assign last    = cnt <= step_n + ONE;

  assign in_ready = state == IDLE;
  assign busy     = state != IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      step      <= 2'd1;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_fact  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      unique case (1'b1)
        state == IDLE: begin
          if (in_valid) begin
            acc  <= W1;
            cnt  <= in_num;
            step <= in_mode ? 2'd2 : 2'd1;
            ovf  <= 1'b0;
            if (in_num <= ONE) begin
              state     <= DONE;
              out_fact  <= W1;
              out_ovf   <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        state == CALC: begin
          acc <= prod[WIDTH-1:0];
          ovf <= ovf_nxt;
          cnt <= cnt - step_n;
          if (last) begin
            // Last product goes straight to the output register.
            state     <= DONE;
            out_fact  <= ovf_nxt ? SAT : prod[WIDTH-1:0];
            out_ovf   <= ovf_nxt;
            out_valid <= 1'b1;
          end
        end
        state == DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_factorial_seq.sv
// Testbench for factorial_seq: directed and random operations vs arithmetic model.
// Covers reset, latency, overflow, double factorial, backpressure, async reset.
module tb_factorial_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_num;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_fact;
  logic        out_ovf;
  logic        busy;

  int passed = 0;
  int total  = 0;

  factorial_seq #(.WIDTH(32), .N_WIDTH(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_num   (in_num),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_fact (out_fact),
    .out_ovf  (out_ovf),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Mathematical n! / n!! with saturation; latency counts clock
  // edges after the accept edge (n<=1 enters DONE on the accept edge).
  task automatic model(input int n, input int m, output logic [31:0] f,
                       output logic o, output int lat);
    longint unsigned r;
    r = 1;
    o = 1'b0;
    for (int k = n; k > 1; k -= (m != 0) ? 2 : 1) begin
      r = r * longint'(k);
      if (r > 64'h0000_0000_FFFF_FFFF) begin
        o = 1'b1;
        break;
      end
    end
    f = o ? 32'hFFFF_FFFF : r[31:0];
    if (n <= 1) lat = 0;
    else if (m != 0) lat = n / 2;
    else lat = n - 1;
  endtask

  task automatic run_op(input int n, input int m);
    logic [31:0] ef;
    logic        eo;
    int          el;
    int          k;
    int          busy_lo;
    model(n, m, ef, eo, el);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_num   = 5'(n);
    in_mode  = m[0];
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    k = 0;
    busy_lo = 0;
    while (out_valid !== 1'b1 && k < 200) begin
      if (busy !== 1'b1) busy_lo++;
      @(posedge clk);
      #1;
      k++;
    end
    chk($sformatf("lat_n%0d_m%0d", n, m), k, el);
    chk($sformatf("fact_n%0d_m%0d", n, m), out_fact, ef);
    chk($sformatf("ovf_n%0d_m%0d", n, m), out_ovf, eo);
    chk("busy_calc", busy_lo, 0);
    chk("busy_done", busy, 1);
    @(posedge clk);
    #1;
    chk("valid_drop", out_valid, 0);
    chk("in_ready_after", in_ready, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_num    = '0;
    in_mode   = 1'b0;
    out_ready = 1'b1;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_fact", out_fact, 0);
    chk("rst_ovf", out_ovf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(0, 0);
    run_op(1, 0);
    run_op(4, 0);
    run_op(6, 0);
    run_op(12, 0);
    run_op(13, 0);
    run_op(31, 0);
    run_op(7, 1);
    run_op(8, 1);
    run_op(2, 1);
    run_op(3, 1);
    run_op(0, 1);
    run_op(31, 1);

    for (int i = 0; i < 20; i++) begin
      run_op(int'($urandom_range(0, 31)), int'($urandom_range(0, 1)));
    end

    // Backpressure with ignored requests during the stall.
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_num   = 5'd5;
    in_mode  = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      in_num   = 5'd3;
      chk("bp_valid", out_valid, 1);
      chk("bp_fact", out_fact, 120);
      chk("bp_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_drop", out_valid, 0);
    chk("bp_in_ready_after", in_ready, 1);
    chk("bp_fact_hold", out_fact, 120);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_ghost", busy, 0);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    in_valid = 1'b1;
    in_num   = 5'd10;
    in_mode  = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_fact", out_fact, 0);
    chk("mid_rst_ovf", out_ovf, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(5, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
